adapter_axi_stream_2_bram: RTL and testbench
============================================

ADAPTER_AXI_STREAM_2_BRAM -- requirements
Module: adapter_axi_stream_2_bram

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, AXI Stream and BRAM data width in bits.
REQ-002 SHALL have parameter BRAM_DEPTH, default 8, BRAM address width; buffer capacity is CAP = 2^BRAM_DEPTH words.
REQ-003 SHALL have parameter USER_DEPTH, default 1, tuser width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_enable  input  1  level; block accepts stream data only while high.
REQ-007 i_axis_user  input  USER_DEPTH  stream sideband.
REQ-008 i_axis_valid  input  1  stream beat valid.
REQ-009 o_axis_ready  output  1  block accepts beat.
REQ-010 i_axis_data  input  AXIS_DATA_WIDTH  beat data.
REQ-011 i_axis_last  input  1  final beat of packet.
REQ-012 o_bram_wea  output  1  registered BRAM write strobe.
REQ-013 o_bram_addr  output  BRAM_DEPTH  registered BRAM write address.
REQ-014 o_bram_data  output  AXIS_DATA_WIDTH  registered BRAM write data.
REQ-015 o_bram_en  output  1  buffer filled, owned by downstream reader.
REQ-016 o_bram_size  output  BRAM_DEPTH+1  words held in buffer, valid while o_bram_en.
REQ-017 o_bram_user  output  USER_DEPTH  tuser captured on first beat of buffer.
REQ-018 o_truncated  output  1  buffer closed by CAP without tlast.
REQ-019 i_bram_done  input  1  one-cycle pulse from reader releasing buffer.

Function
REQ-020 SHALL implement states IDLE, WRITE, FLUSH, HANDOFF.
REQ-021 IDLE: o_axis_ready=0, count=0; go WRITE when i_enable=1.
REQ-022 WRITE: o_axis_ready=1 exactly when state==WRITE (combinational from state only, not from i_axis_valid).
REQ-023 Beat accepted when i_axis_valid && o_axis_ready at cycle N; next cycle o_bram_wea=1, o_bram_addr=count (pre-increment), o_bram_data=beat data; count increments by 1.
REQ-024 o_bram_wea SHALL be 0 in every cycle not following an accepted beat.
REQ-025 First accepted beat of a buffer (count==0) SHALL latch i_axis_user into o_bram_user.
REQ-026 Accepted beat with i_axis_last=1 SHALL move WRITE->FLUSH, o_truncated<=0.
REQ-027 Accepted beat making count==CAP with i_axis_last=0 SHALL move WRITE->FLUSH, o_truncated<=1; next beat starts a new buffer.
REQ-028 Beat that is both last and CAP-th SHALL give o_truncated=0.
REQ-029 FLUSH lasts one cycle (final write strobe visible), then HANDOFF with o_bram_size=count and o_bram_en=1; o_bram_en rises 2 cycles after final beat acceptance.
REQ-030 HANDOFF: o_axis_ready=0; o_bram_en, o_bram_size, o_bram_user, o_truncated held stable.
REQ-031 i_bram_done=1 in HANDOFF SHALL, next cycle, clear o_bram_en, count=0, state=WRITE if i_enable else IDLE; i_bram_done ignored in other states.
REQ-032 i_enable=0 in WRITE with count==0 SHALL return to IDLE; with count>0 SHALL finish current buffer normally (enable only gates starting a buffer).
REQ-033 count SHALL be BRAM_DEPTH+1 bits and never exceed CAP; o_bram_addr wraps never within one buffer.
REQ-034 Back-to-back beats SHALL be accepted every cycle in WRITE (full throughput).

Reset
REQ-035 rst=1 SHALL force state IDLE, count=0, o_axis_ready=0, o_bram_wea=0, o_bram_addr=0, o_bram_data=0, o_bram_en=0, o_bram_size=0, o_bram_user=0, o_truncated=0.
REQ-036 rst mid-buffer or in HANDOFF SHALL discard the buffer; no o_bram_en pulse afterwards until a new buffer completes.

Verification
REQ-037 Reset, i_enable=1, 4 beats 0xA0..0xA3 with last on 4th -> wea on addrs 0..3 with matching data, o_bram_en=1 two cycles after last, size=4, truncated=0.
REQ-038 BRAM_DEPTH=2, 6 continuous beats no last -> first buffer size=4 truncated=1, ready=0 until i_bram_done, then beats 5..6 written to addrs 0..1.
REQ-039 Single beat with last, user=1 -> size=1, o_bram_user=1, writes only addr 0.
REQ-040 Valid toggling every other cycle, 3 beats -> wea exactly 3 cycles, addrs 0,1,2, no gaps in address.
REQ-041 HANDOFF held 10 cycles with valid=1 -> no wea, outputs stable; i_bram_done pulse -> o_bram_en=0 next cycle, ready=1.
REQ-042 rst asserted after 2 beats of 4 -> all outputs reset values; next 3-beat packet gives size=3 starting at addr 0.

Source files
------------

// File: rtl/adapter_axi_stream_2_bram.sv
// AXI Stream to BRAM write adapter: packs stream beats into a 2^BRAM_DEPTH-word
// buffer and hands the filled buffer to a downstream reader until it releases it.
module adapter_axi_stream_2_bram #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int BRAM_DEPTH      = 8,
  parameter int USER_DEPTH      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
  input  logic [USER_DEPTH-1:0]      i_axis_user,
  input  logic                       i_axis_valid,
  output logic                       o_axis_ready,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_data,
  input  logic                       i_axis_last,
  output logic                       o_bram_wea,
  output logic [BRAM_DEPTH-1:0]      o_bram_addr,
  output logic [AXIS_DATA_WIDTH-1:0] o_bram_data,
  output logic                       o_bram_en,
  output logic [BRAM_DEPTH:0]        o_bram_size,
  output logic [USER_DEPTH-1:0]      o_bram_user,
  output logic                       o_truncated,
  input  logic                       i_bram_done
);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, HANDOFF} state_t;

  localparam logic [BRAM_DEPTH:0] CAP = {1'b1, {BRAM_DEPTH{1'b0}}};

  state_t                     state_q, state_d;
  logic [BRAM_DEPTH:0]        count_q, count_d;
  logic                       wea_q, wea_d;
  logic [BRAM_DEPTH-1:0]      addr_q, addr_d;
  logic [AXIS_DATA_WIDTH-1:0] data_q, data_d;
  logic                       en_q, en_d;
  logic [BRAM_DEPTH:0]        size_q, size_d;
  logic [USER_DEPTH-1:0]      user_q, user_d;
  logic                       trunc_q, trunc_d;

  logic                       accept;
  logic [BRAM_DEPTH:0]        count_inc;

  // Ready is a pure function of state, so a beat is taken whenever valid is seen in WRITE.
  assign accept    = i_axis_valid && (state_q == WRITE);
  assign count_inc = count_q + 1'b1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      size_q  <= '0;
      user_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      size_q  <= size_d;
      user_q  <= user_d;
      trunc_q <= trunc_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = WRITE;
      WRITE: begin
        if (accept) begin
          if (i_axis_last || count_inc == CAP) state_d = FLUSH;
        end else if (!i_enable && count_q == '0) begin
          state_d = IDLE;
        end
      end
      FLUSH:   state_d = HANDOFF;
      HANDOFF: if (i_bram_done) state_d = i_enable ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    wea_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    size_d  = size_q;
    user_d  = user_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE: count_d = '0;
      WRITE: begin
        if (accept) begin
          wea_d   = 1'b1;
          addr_d  = count_q[BRAM_DEPTH-1:0];
          data_d  = i_axis_data;
          count_d = count_inc;
          if (count_q == '0) user_d = i_axis_user;
          // A beat that is both last and CAP-th still counts as a clean close.
          if (i_axis_last)            trunc_d = 1'b0;
          else if (count_inc == CAP)  trunc_d = 1'b1;
        end
      end
      FLUSH: begin
        en_d   = 1'b1;
        size_d = count_q;
      end
      HANDOFF: begin
        if (i_bram_done) begin
          en_d    = 1'b0;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_axis_ready = (state_q == WRITE);
    o_bram_wea   = wea_q;
    o_bram_addr  = addr_q;
    o_bram_data  = data_q;
    o_bram_en    = en_q;
    o_bram_size  = size_q;
    o_bram_user  = user_q;
    o_truncated  = trunc_q;
  end

endmodule

// File: tb/tb_adapter_axi_stream_2_bram.sv
// Scoreboard bench for adapter_axi_stream_2_bram with a 4-word buffer: directed
// scenarios followed by random packets, enable toggling and random reader latency.
module tb_adapter_axi_stream_2_bram;

  localparam int DW  = 32;
  localparam int BD  = 2;
  localparam int UW  = 2;
  localparam int CAP = 1 << BD;

  typedef struct {
    logic [BD-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            size;
    logic [UW-1:0] user;
    logic          trunc;
    int            rise;
  } buf_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [UW-1:0] i_axis_user;
  logic          i_axis_valid;
  logic          o_axis_ready;
  logic [DW-1:0] i_axis_data;
  logic          i_axis_last;
  logic          o_bram_wea;
  logic [BD-1:0] o_bram_addr;
  logic [DW-1:0] o_bram_data;
  logic          o_bram_en;
  logic [BD:0]   o_bram_size;
  logic [UW-1:0] o_bram_user;
  logic          o_truncated;
  logic          i_bram_done;

  adapter_axi_stream_2_bram #(
    .AXIS_DATA_WIDTH(DW), .BRAM_DEPTH(BD), .USER_DEPTH(UW)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_axis_user(i_axis_user), .i_axis_valid(i_axis_valid), .o_axis_ready(o_axis_ready),
    .i_axis_data(i_axis_data), .i_axis_last(i_axis_last),
    .o_bram_wea(o_bram_wea), .o_bram_addr(o_bram_addr), .o_bram_data(o_bram_data),
    .o_bram_en(o_bram_en), .o_bram_size(o_bram_size), .o_bram_user(o_bram_user),
    .o_truncated(o_truncated), .i_bram_done(i_bram_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a buffer is a run of accepted words that closes on tlast or at CAP.
  wr_t           wq[$];
  buf_t          bq[$];
  int            m_count  = 0;
  int            m_writes = 0;
  logic [UW-1:0] m_user   = '0;

  function automatic void model_accept(input logic [DW-1:0] d, input logic [UW-1:0] u,
                                       input logic l);
    wr_t  w;
    buf_t b;
    if (m_count == 0) m_user = u;
    w.addr = m_count[BD-1:0];
    w.data = d;
    wq.push_back(w);
    m_writes++;
    m_count++;
    if (l || m_count == CAP) begin
      b.size  = m_count;
      b.user  = m_user;
      b.trunc = !l;
      b.rise  = cyc + 2;
      bq.push_back(b);
      m_count = 0;
    end
  endfunction

  // Monitor: consumes expected writes and buffer handoffs as the DUT presents them.
  int   n_wea   = 0;
  logic en_prev = 1'b0;
  buf_t cur_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (o_bram_wea === 1'b1) begin
        n_wea++;
        if (wq.size() == 0) begin
          check("unexpected_wea", o_bram_wea, 1'b0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("bram_addr", 64'(o_bram_addr), 64'(w.addr));
          check("bram_data", 64'(o_bram_data), 64'(w.data));
        end
      end
      if (o_bram_en === 1'b1 && !en_prev) begin
        if (bq.size() == 0) begin
          check("unexpected_en", o_bram_en, 1'b0);
          cur_exp = '{size: int'(o_bram_size), user: o_bram_user, trunc: o_truncated, rise: 0};
        end else begin
          cur_exp = bq.pop_front();
          check("en_rise_cycle", 64'(cyc), 64'(cur_exp.rise));
        end
      end
      if (o_bram_en === 1'b1) begin
        check("handoff_size",  64'(o_bram_size), 64'(cur_exp.size));
        check("handoff_user",  64'(o_bram_user), 64'(cur_exp.user));
        check("handoff_trunc", 64'(o_truncated), 64'(cur_exp.trunc));
        check("handoff_ready", 64'(o_axis_ready), 64'd0);
        check("handoff_wea",   64'(o_bram_wea),   64'd0);
      end
      en_prev = (o_bram_en === 1'b1);
    end
  end

  // Reader: holds each filled buffer for a while, then pulses done.
  int   force_hold  = 0;
  bit   reader_busy = 1'b0;
  logic en_at;
  initial begin
    i_bram_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_bram_en === 1'b1 && !reader_busy) begin
        reader_busy = 1'b1;
        repeat (force_hold > 0 ? force_hold : int'($urandom_range(0, 12))) @(negedge clk);
        i_bram_done = 1'b1;
        @(posedge clk);
        en_at = i_enable;
        @(negedge clk);
        i_bram_done = 1'b0;
        check("en_after_done",    64'(o_bram_en),    64'd0);
        check("ready_after_done", 64'(o_axis_ready), 64'(en_at));
        reader_busy = 1'b0;
      end
    end
  end

  bit tog_on = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_on && $urandom_range(0, 15) == 0) i_enable = ~i_enable;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // Entered and left on a falling edge; the beat is taken at the following rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l,
                           input int gap);
    int guard;
    if (gap > 0) begin
      i_axis_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    i_axis_valid = 1'b1;
    i_axis_data  = d;
    i_axis_user  = u;
    i_axis_last  = l;
    guard = 0;
    while (o_axis_ready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (o_axis_ready !== 1'b1) begin
      check("accept_timeout", 64'(o_axis_ready), 64'd1);
      i_axis_valid = 1'b0;
    end else begin
      model_accept(d, u, l);
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [UW-1:0] u,
                          input bit close, input int gap);
    for (int i = 0; i < len; i++)
      send_beat(base + DW'(i), u, close && (i == len - 1), (i == 0) ? 0 : gap);
    i_axis_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(bq.size() == 0 && wq.size() == 0 && o_bram_en === 1'b0 && !reader_busy)
           && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(bq.size() + wq.size()), 64'd0);
  endtask

  task automatic check_reset();
    check("rst_ready", 64'(o_axis_ready), 64'd0);
    check("rst_wea",   64'(o_bram_wea),   64'd0);
    check("rst_addr",  64'(o_bram_addr),  64'd0);
    check("rst_data",  64'(o_bram_data),  64'd0);
    check("rst_en",    64'(o_bram_en),    64'd0);
    check("rst_size",  64'(o_bram_size),  64'd0);
    check("rst_user",  64'(o_bram_user),  64'd0);
    check("rst_trunc", 64'(o_truncated),  64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    i_enable     = 1'b0;
    i_axis_valid = 1'b0;
    i_axis_data  = '0;
    i_axis_user  = '0;
    i_axis_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    rst      = 1'b0;
    i_enable = 1'b1;
    @(negedge clk);

    send_pkt(4, 32'hA0, 2'd2, 1'b1, 0);
    wait_idle();

    send_pkt(6, 32'h100, 2'd3, 1'b0, 0);
    send_pkt(1, 32'h106, 2'd0, 1'b1, 0);
    wait_idle();

    send_pkt(1, 32'h55, 2'd1, 1'b1, 0);
    wait_idle();

    send_pkt(3, 32'h200, 2'd2, 1'b1, 1);
    wait_idle();

    force_hold = 10;
    send_pkt(2, 32'h300, 2'd1, 1'b1, 0);
    send_pkt(2, 32'h310, 2'd3, 1'b1, 0);
    wait_idle();
    force_hold = 0;

    send_pkt(2, 32'h400, 2'd3, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    @(negedge clk);
    check_reset();
    check("reset_pending_writes", 64'(wq.size()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(3, 32'h500, 2'd1, 1'b1, 0);
    wait_idle();

    tog_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int            len;
      logic [UW-1:0] u;
      len = $urandom_range(1, 9);
      u   = UW'($urandom);
      for (int i = 0; i < len; i++)
        send_beat(DW'($urandom), u, i == len - 1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      i_axis_valid = 1'b0;
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    tog_on = 1'b0;
    @(negedge clk);
    i_enable = 1'b1;
    wait_idle();
    repeat (5) @(negedge clk);

    check("leftover_writes",  64'(wq.size()), 64'd0);
    check("leftover_buffers", 64'(bq.size()), 64'd0);
    check("total_wea",        64'(n_wea),     64'(m_writes));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
